// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencer: fetches one word per req/ack transaction,
// holds it for the decoder, and picks the next PC from exception/jump/branch.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        jump,
   input  logic        branch,
   input  logic        exception,
   input  logic        zero,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic [31:0] epc,
   output logic [31:0] instr_count,
   output logic [1:0]  o_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_epc;
   logic [31:0] r_count;
   logic        r_req;
   logic        r_valid;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_jump_target;
   logic [31:0] w_br_offset;
   logic [31:0] w_br_target;

   assign w_pc_plus4    = r_pc + 32'd4;
   assign w_jump_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
   assign w_br_offset   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_br_target   = w_pc_plus4 + w_br_offset;

   // Handshakes: a memory word transfers on an edge with imem_req && imem_ack;
   // an instruction is consumed on an edge with instr_valid && instr_ready.
   // Decoder feedback (jump/branch/exception/zero) is only looked at on that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_instr <= 32'd0;
         r_epc   <= 32'd0;
         r_count <= 32'd0;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_REQ;
               r_req   <= 1'b1;
            end
            S_REQ: begin
               if (imem_ack) begin
                  r_instr <= imem_rdata;
                  r_state <= S_HOLD;
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (instr_ready) begin
                  if (exception) begin
                     r_pc  <= EXC_VECTOR;
                     r_epc <= r_pc;
                  end else if (jump) begin
                     r_pc <= w_jump_target;
                  end else if (branch && zero) begin
                     r_pc <= w_br_target;
                  end else begin
                     r_pc <= w_pc_plus4;
                  end
                  r_count <= r_count + 32'd1;
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign opcode      = r_instr[31:26];
   assign instr_valid = r_valid;
   assign pc_out      = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign epc         = r_epc;
   assign instr_count = r_count;
   assign o_state     = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// checked against an architectural PC/EPC/count model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC  = 32'h8000_0180;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump;
   logic        branch;
   logic        exception;
   logic        zero;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic [31:0] epc;
   logic [31:0] instr_count;
   logic [1:0]  state_dbg;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] m_pc;
   logic [31:0] m_epc;
   logic [31:0] m_count;
   logic [31:0] m_instr;

   fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VEC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .jump        (jump),
      .branch      (branch),
      .exception   (exception),
      .zero        (zero),
      .pc_out      (pc_out),
      .pc_plus4    (pc_plus4),
      .epc         (epc),
      .instr_count (instr_count),
      .o_state     (state_dbg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl_x();
      jump      = 1'bx;
      branch    = 1'bx;
      exception = 1'bx;
      zero      = 1'bx;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = $urandom;
      instr_ready = 1'b0;
      ctrl_x();
      step();
      step();
      m_pc    = RESET_PC;
      m_epc   = 32'd0;
      m_count = 32'd0;
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_opcode", {26'd0, opcode}, 32'd0);
      chk("rst_epc", epc, 32'd0);
      chk("rst_count", instr_count, 32'd0);
      chk("rst_pc_out", pc_out, RESET_PC);
      chk("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
      chk("rst_addr", imem_addr, RESET_PC);
      rst = 1'b0;
      step();
      chk1("first_req", imem_req, 1'b1);
      chk("first_addr", imem_addr, m_pc);
   endtask

   // Memory side: hold off ack for d cycles, then return word w.
   task automatic fetch(input logic [31:0] w, input int d);
      chk1("fetch_req", imem_req, 1'b1);
      for (int k = 0; k < d; k++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         step();
         chk1("stall_req", imem_req, 1'b1);
         chk1("stall_valid", instr_valid, 1'b0);
         chk("stall_addr", imem_addr, m_pc);
      end
      imem_ack   = 1'b1;
      imem_rdata = w;
      step();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      m_instr    = w;
      chk1("fetch_valid", instr_valid, 1'b1);
      chk1("fetch_req_low", imem_req, 1'b0);
      chk("fetch_instr", instr, w);
      chk("fetch_opcode", {26'd0, opcode}, {26'd0, w[31:26]});
      chk("fetch_pc_out", pc_out, m_pc);
      chk("fetch_pc_plus4", pc_plus4, m_pc + 32'd4);
   endtask

   // Decoder side: hold off ready for d cycles (controls X, stray acks), then accept.
   task automatic accept(input int d, input logic j, input logic b, input logic e, input logic z);
      logic [31:0] seq;
      int          off;
      for (int k = 0; k < d; k++) begin
         instr_ready = 1'b0;
         ctrl_x();
         imem_ack    = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         step();
         chk1("hold_valid", instr_valid, 1'b1);
         chk1("hold_req", imem_req, 1'b0);
         chk("hold_instr", instr, m_instr);
         chk("hold_pc", pc_out, m_pc);
         chk("hold_count", instr_count, m_count);
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      jump        = j;
      branch      = b;
      exception   = e;
      zero        = z;
      step();
      instr_ready = 1'b0;
      ctrl_x();
      seq = m_pc + 32'd4;
      off = $signed(m_instr[15:0]);
      if (e) begin
         m_epc = m_pc;
         m_pc  = EXC_VEC;
      end else if (j) begin
         m_pc = {seq[31:28], m_instr[25:0], 2'b00};
      end else if (b && z) begin
         m_pc = seq + 32'(off * 4);
      end else begin
         m_pc = seq;
      end
      m_count = m_count + 32'd1;
      chk1("acc_req", imem_req, 1'b1);
      chk1("acc_valid", instr_valid, 1'b0);
      chk("acc_addr", imem_addr, m_pc);
      chk("acc_epc", epc, m_epc);
      chk("acc_count", instr_count, m_count);
   endtask

   initial begin
      int t0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;
      instr_ready = 1'b0;
      ctrl_x();

      // Sequential fetch, back-to-back handshakes
      do_reset();
      t0 = cyc;
      for (int i = 0; i < 4; i++) begin
         chk("seq_addr", imem_addr, 32'(i * 4));
         fetch(32'h2008_0005, 0);
         chk("seq_opcode", {26'd0, opcode}, 32'd8);
         accept(0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("seq_cycles", 32'(cyc - t0), 32'd8);
      chk("seq_count", instr_count, 32'd4);

      // Stalls: 3-cycle ack delay plus 2-cycle ready delay
      t0 = cyc;
      fetch(32'h0000_0020, 3);
      accept(2, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("stall_cycles", 32'(cyc - t0), 32'd7);
      chk("stall_count", instr_count, 32'd5);

      // Branch taken / not taken at 0x40
      fetch(32'h0800_0010, 0);
      accept(0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("jump_to_40", imem_addr, 32'h0000_0040);
      fetch(32'h1000_FFFC, 1);
      accept(1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("beq_taken", imem_addr, 32'h0000_0034);
      fetch(32'h0800_0010, 0);
      accept(0, 1'b1, 1'b0, 1'b0, 1'b0);
      fetch(32'h1000_FFFC, 0);
      accept(0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("beq_not_taken", imem_addr, 32'h0000_0044);

      // Jump in the 0x1000_0000 region, then jump overlapped by exception
      fetch(32'h0BFF_FFFF, 0);
      accept(0, 1'b1, 1'b0, 1'b0, 1'b0);
      fetch(32'h0000_0000, 0);
      accept(0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reach_1000", imem_addr, 32'h1000_0000);
      fetch(32'h0800_0010, 0);
      accept(0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("jump_1000_0040", imem_addr, 32'h1000_0040);
      fetch(32'h0800_0000, 0);
      accept(0, 1'b1, 1'b0, 1'b0, 1'b0);
      fetch(32'h0800_0010, 0);
      accept(0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("exc_vector", imem_addr, 32'h8000_0180);
      chk("exc_epc", epc, 32'h1000_0000);

      // Backward branch past 0, then sequential wrap with X controls during stall
      do_reset();
      fetch(32'h1000_FFFE, 0);
      accept(0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("branch_wrap", imem_addr, 32'hFFFF_FFFC);
      fetch(32'h0000_0000, 2);
      accept(3, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("seq_wrap", imem_addr, 32'h0000_0000);

      // Reset on the same edge as an ack
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      rst        = 1'b1;
      step();
      imem_ack   = 1'b0;
      rst        = 1'b0;
      m_pc       = RESET_PC;
      m_epc      = 32'd0;
      m_count    = 32'd0;
      chk1("midrst_valid", instr_valid, 1'b0);
      chk1("midrst_req", imem_req, 1'b0);
      chk("midrst_pc", pc_out, RESET_PC);
      chk("midrst_instr", instr, 32'd0);
      chk("midrst_count", instr_count, 32'd0);
      step();
      chk1("midrst_restart_req", imem_req, 1'b1);
      chk("midrst_restart_addr", imem_addr, RESET_PC);
      fetch(32'h2008_0005, 0);
      accept(0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 80; i++) begin
         fetch($urandom, $urandom_range(0, 3));
         accept($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
